// File: rtl/dma_fifo_mr.sv
// Synchronous FIFO for the DMA data path with occupancy/threshold flags and
// a mark/rewind/commit retry window so that a failed burst can be replayed.
module dma_fifo_mr #(
  parameter int DATA      = 8,
  parameter int ADDR_SIZE = 4,
  parameter int AE_LVL    = 2,
  parameter int AF_LVL    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA-1:0]      wr_data,
  input  logic                 rd_en,
  output logic [DATA-1:0]      rd_data,
  output logic                 rd_valid,
  input  logic                 mark,
  input  logic                 rewind,
  input  logic                 commit,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 hold,
  output logic                 wr_err,
  output logic                 rd_err
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AE_P    = PW'(AE_LVL);
  localparam logic [PW-1:0] AF_P    = PW'(AF_LVL);

  logic [DATA-1:0] mem [DEPTH];

  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   markPtr_q, markPtr_d;
  logic            hold_q, hold_d;
  logic            rdValid_q, rdValid_d;
  logic [DATA-1:0] rdData_q, rdData_d;
  logic            wrErr_q, wrErr_d;
  logic            rdErr_q, rdErr_d;

  logic [PW-1:0]   basePtr;
  logic [PW-1:0]   used;
  logic [PW-1:0]   readable;
  logic            isFull;
  logic            isEmpty;
  logic            wrAcc;
  logic            rdAcc;

  // While holding, entries read since the mark still occupy space, so
  // fullness is measured from the mark rather than from the read pointer.
  assign basePtr  = hold_q ? markPtr_q : rdPtr_q;
  assign used     = wrPtr_q - basePtr;
  assign readable = wrPtr_q - rdPtr_q;
  assign isFull   = (used == DEPTH_P);
  assign isEmpty  = (readable == '0);
  assign wrAcc    = wr_en & ~isFull;
  assign rdAcc    = rd_en & ~isEmpty & ~rewind;

  always_comb begin
    wrPtr_d   = wrPtr_q + {{ADDR_SIZE{1'b0}}, wrAcc};
    rdPtr_d   = rdPtr_q + {{ADDR_SIZE{1'b0}}, rdAcc};
    markPtr_d = markPtr_q;
    hold_d    = hold_q;
    rdValid_d = rdAcc;
    rdData_d  = rdAcc ? mem[rdPtr_q[ADDR_SIZE-1:0]] : rdData_q;
    wrErr_d   = wr_en & isFull;
    rdErr_d   = rd_en & isEmpty & ~rewind;
    if (mark && !hold_q) begin
      markPtr_d = rdPtr_q + {{ADDR_SIZE{1'b0}}, rdAcc};
      hold_d    = 1'b1;
    end
    // Rewind takes effect before a same-cycle commit releases the window.
    if (rewind && hold_q) begin
      rdPtr_d = markPtr_q;
    end
    if (commit && hold_q) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      markPtr_q <= '0;
      hold_q    <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
      wrErr_q   <= 1'b0;
      rdErr_q   <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      markPtr_q <= markPtr_d;
      hold_q    <= hold_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
      wrErr_q   <= wrErr_d;
      rdErr_q   <= rdErr_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wrAcc) begin
      mem[wrPtr_q[ADDR_SIZE-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rdData_q;
  assign rd_valid     = rdValid_q;
  assign full         = isFull;
  assign empty        = isEmpty;
  assign almost_full  = (used >= AF_P);
  assign almost_empty = (readable <= AE_P);
  assign count        = readable;
  assign hold         = hold_q;
  assign wr_err       = wrErr_q;
  assign rd_err       = rdErr_q;

endmodule

// File: doc/dma_fifo_mr.md
Name: dma_fifo_mr

Overview:
- Parametrised synchronous FIFO for the DMA controller data path. Successor of the single-buffer FIFO.
- Adds: generic width and depth, concurrent read and write in one cycle, an occupancy count, and programmable almost-empty/almost-full thresholds.
- Adds mark/rewind/commit retry: the DMA FSM can replay a burst after a bus error without losing data.
- Sits between the source-side bus master (writer) and the destination-side bus master (reader).

Parameters:
- DATA, 8, data word width in bits.
- ADDR_SIZE, 4, log2 of depth; depth = 2**ADDR_SIZE entries.
- AE_LVL, 2, almost_empty asserted when count <= AE_LVL.
- AF_LVL, 14, almost_full asserted when used >= AF_LVL.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  write request.
- wr_data  input  DATA  write data.
- rd_en  input  1  read request.
- rd_data  output  DATA  registered read data.
- rd_valid  output  1  rd_data holds a word accepted on the previous cycle.
- mark  input  1  snapshot read pointer and start hold.
- rewind  input  1  restore read pointer to the snapshot.
- commit  input  1  end hold and release retained entries.
- full  output  1  no free entry (used == depth).
- empty  output  1  no readable entry (count == 0).
- almost_full  output  1  used >= AF_LVL.
- almost_empty  output  1  count <= AE_LVL.
- count  output  ADDR_SIZE+1  readable entries, wr_ptr - rd_ptr.
- hold  output  1  mark is active.
- wr_err  output  1  one-cycle pulse: write attempted while full.
- rd_err  output  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset (asynchronous, rst=1):
  - Pointers, mark_ptr, count, hold, rd_valid, wr_err and rd_err all go to 0.
  - rd_data goes to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LVL>0).
  - Storage contents are not reset.
- Pointers:
  - wr_ptr, rd_ptr and mark_ptr are ADDR_SIZE+1 bits; the MSB is a wrap bit.
  - Subtraction is modulo 2**(ADDR_SIZE+1).
  - Memory is indexed by the low ADDR_SIZE bits.
- Base pointer and occupancy:
  - base = hold ? mark_ptr : rd_ptr.
  - used = wr_ptr - base.
  - full = (used == depth).
  - All status outputs are combinational from registered pointers, so they reflect the state after the last edge.
- Write: accepted iff wr_en & ~full. Data is stored at wr_ptr and wr_ptr increments. If full, the write is dropped and wr_err pulses the next cycle.
- Read:
  - Accepted iff rd_en & ~empty & ~rewind.
  - On acceptance, rd_data <= mem[rd_ptr], rd_ptr increments and rd_valid=1 next cycle.
  - Otherwise rd_valid=0 and rd_data holds its value.
  - rd_en & empty pulses rd_err.
  - Read latency: 1 cycle.
- Simultaneous read and write:
  - Each side is evaluated against pre-edge flags. There is no write-through.
  - A write to an empty FIFO is readable from the next cycle.
  - When full with hold=0, an accepted read does not admit a same-cycle write.
- mark (when hold=0): mark_ptr <= rd_ptr + (read accepted this cycle ? 1 : 0); hold <= 1. mark while hold=1 is ignored.
- rewind (when hold=1):
  - rd_ptr <= mark_ptr.
  - Any rd_en that cycle is ignored and does not raise rd_err.
  - hold stays 1.
  - rewind while hold=0 is ignored.
- commit (when hold=1): hold <= 0 and retained entries become free. Same-cycle priority: rewind is applied first, then commit.
- Retention: while hold=1, entries read since mark stay occupied (count drops, used does not). full can therefore assert with count < depth.
- Wrap-around: pointers roll over past 2**(ADDR_SIZE+1)-1 with no special case.
- Reset mid-operation: all in-flight state is discarded immediately. The cycle after rst deasserts behaves as a freshly empty FIFO.

Test Plan:
- Fill/drain, depth 16: write 0x00..0x0F.
  - full=1 after the 16th edge; count=16.
  - A 17th write pulses wr_err and count stays 16.
  - Reading 16 words returns 0x00..0x0F with rd_valid one cycle after each rd_en; empty=1 at the end.
- Concurrent access: with count=5, assert wr_en and rd_en for 40 cycles.
  - count holds at 5 and data stays in order across two pointer wraps.
  - No wr_err or rd_err.
- Retry: write 0xA0..0xA7, mark, then read 4 words (0xA0..0xA3).
  - rewind: count returns to 8 and the next reads give 0xA0..0xA3 again.
  - commit after all 8 are read: full=0 and used=0.
- Retention full: mark at count=16, read 3 words.
  - full stays 1 with count=13.
  - A write pulses wr_err.
  - commit: full=0 and the write is accepted the next cycle.
- Thresholds: AE_LVL=2, AF_LVL=14. Step the count 0 to 16 and back.
  - almost_empty is 1 for count 0..2.
  - almost_full is 1 for used 14..16.
- Async reset: assert rst mid-burst, between clock edges, with hold=1 and count=9.
  - Outputs go to reset values without a clock edge.
  - After release, the first write/read returns the new data only.
